// File: rtl/pid_hit_buffer.sv
// pid_hit_buffer
// Readout stage behind the fine-time PID discriminator. Non-empty hit words
// are tagged with the particle flags and a 13-bit coarse timestamp and are
// stored in a small FIFO. Saturating per-class hit counters run alongside.
// Slow control reads the FIFO and the counters over the wired-OR local bus.
module pid_hit_buffer #(
  parameter logic [7:0] Base      = 8'hE8,
  parameter int         DepthLog2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Result,
  input  logic        Electron,
  input  logic        Muon,
  input  logic        Pion,
  input  logic [31:0] DataIn,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] DataOut,
  output logic        NotEmpty,
  output logic        Overflow
);

  localparam int Depth = 1 << DepthLog2;
  localparam int CntW  = DepthLog2 + 1;

  // Register offsets relative to Base
  localparam logic [7:0] OffCtrl = 8'd0;
  localparam logic [7:0] OffData = 8'd1;
  localparam logic [7:0] OffTag  = 8'd2;
  localparam logic [7:0] OffEP   = 8'd3;
  localparam logic [7:0] OffM    = 8'd4;

  // Counter slots inside the packed counter vector
  localparam int IdxE = 0;
  localparam int IdxM = 1;
  localparam int IdxP = 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [12:0]          r_ts;
  logic                 r_en;
  logic                 r_ovf;
  logic                 r_read_d;
  logic [DepthLog2-1:0] r_wr_ptr;
  logic [DepthLog2-1:0] r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [47:0]          r_mem [Depth];

  // ---------------------------------------------------------------------------
  // Decode and FIFO control
  // ---------------------------------------------------------------------------
  logic [7:0]       w_offset;
  logic             w_in_range;
  logic             w_ctrl_wr;
  logic             w_clear;
  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [2:0]       w_flags;
  logic [47:0]      w_head;
  logic [31:0]      w_head_result;
  logic [15:0]      w_head_tag;
  logic [4:0]       w_count_field;
  logic [31:0]      w_status;
  logic [2:0][15:0] w_cnt;
  logic             w_unused;

  // Offset arithmetic is modulo 256, so a Base near the top of the map still
  // decodes its five consecutive addresses.
  assign w_offset   = Address - Base;
  assign w_in_range = (w_offset <= OffM);

  assign w_ctrl_wr  = Write && (w_offset == OffCtrl);
  assign w_clear    = w_ctrl_wr && DataIn[1];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntW'(Depth));

  assign w_flags    = {Pion, Muon, Electron};

  // Only non-empty words are worth storing; counters look at flags alone.
  assign w_push_req = r_en && (Result != 32'd0);

  // A pop is the first cycle of a read of the tag register. Holding Read high
  // keeps returning data but never pops twice.
  assign w_pop_req  = Read && !r_read_d && (w_offset == OffTag);
  assign w_pop      = w_pop_req && !w_empty;

  // When full, a push is only accepted if a pop frees a slot in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // The storage holds stale data once popped, so the head is masked when empty.
  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_result = w_empty ? 32'd0 : w_head[47:16];
  assign w_head_tag    = w_empty ? 16'd0 : w_head[15:0];

  assign w_count_field = 5'(r_count);
  assign w_status      = {r_en, 20'd0, r_ovf, w_full, w_empty, 3'd0, w_count_field};

  // Upper write-data bits have no meaning in the control register.
  assign w_unused = ^DataIn[31:2];

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Free-running coarse timestamp, wraps naturally at 13 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= 13'd0;
    end else begin
      r_ts <= r_ts + 13'd1;
    end
  end

  // Capture enable; powers up enabled so hits are recorded without setup
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_en <= DataIn[0];
    end
  end

  // Previous Read level for pop edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_d <= 1'b0;
    end else begin
      r_read_d <= Read;
    end
  end

  // FIFO storage write; no reset needed because pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && !w_clear && w_push) begin
      r_mem[r_wr_ptr] <= {Result, w_flags, r_ts};
    end
  end

  // FIFO pointers, occupancy and sticky overflow; clear beats push and pop
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // One saturating counter per particle class
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [15:0] r_cnt;

    // Count enabled cycles carrying this class flag, stick at all-ones
    always_ff @(posedge clk) begin
      if (rst || w_clear) begin
        r_cnt <= 16'd0;
      end else if (r_en && w_flags[gi] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end

    assign w_cnt[gi] = r_cnt;
  end

  // ---------------------------------------------------------------------------
  // Local-bus read mux; drives zero unless this block is being read
  // ---------------------------------------------------------------------------

  // Combinational readback from registered state
  always_comb begin
    DataOut = 32'd0;
    if (Read && w_in_range) begin
      case (w_offset)
        OffCtrl: DataOut = w_status;
        OffData: DataOut = w_head_result;
        OffTag:  DataOut = {16'd0, w_head_tag};
        OffEP:   DataOut = {w_cnt[IdxP], w_cnt[IdxE]};
        OffM:    DataOut = {16'd0, w_cnt[IdxM]};
        default: DataOut = 32'd0;
      endcase
    end
  end

  assign NotEmpty = !w_empty;
  assign Overflow = r_ovf;

endmodule

// File: doc/pid_hit_buffer.md
# pid_hit_buffer

Per-channel readout stage directly downstream of the fine-time PID discriminator. On every 50 MHz cycle it takes the decoded leading-edge word (`Result`) and the Electron/Muon/Pion match flags, time-stamps non-empty words with a free-running coarse counter, and stores them in a 16-entry FIFO. It also keeps saturating per-class hit counters. Both the FIFO and the counters are read over the shared local bus, so slow control can inspect individual hits without a logic analyzer.

## Interface
Parameters:
- `Base`, default `8'hE8`: local-bus base address; the block decodes `Base` to `Base+4`.
- `DepthLog2`, default `4`: FIFO depth is 2^DepthLog2 (16 entries).

Ports:
- `clk`  in  1: 50 MHz system clock (the same clock as upstream `clk[2]`). Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `Result`  in  32: decoded hit word from the upstream stage, registered upstream.
- `Electron`  in  1: electron match flag, aligned with `Result`.
- `Muon`  in  1: muon match flag, aligned with `Result`.
- `Pion`  in  1: pion match flag, aligned with `Result`.
- `DataIn`  in  32: local-bus write data.
- `Address`  in  8: local-bus address.
- `Read`  in  1: local-bus read strobe (level).
- `Write`  in  1: local-bus write strobe (level).
- `DataOut`  out  32: local-bus read data. Wired-OR bus: it is 0 whenever this block is not addressed.
- `NotEmpty`  out  1: the FIFO holds at least one entry.
- `Overflow`  out  1: sticky flag; a hit was dropped because the FIFO was full.

## Operation
- **Timestamp**
  - `ts` is a 13-bit free-running counter, incremented every cycle.
  - It wraps from 8191 to 0 and is reset to 0.
- **Push**
  - Condition: `en` is 1 and `Result != 0`.
  - Entry = {`Result[31:0]`, tag}, where tag = {`Pion`, `Muon`, `Electron`, `ts[12:0]`} (16 bits).
  - `ts` is the counter value in the cycle the input is sampled.
- **Counters**
  - Three 16-bit counters (`ecnt`, `mcnt`, `pcnt`), one per flag.
  - Each increments on a cycle where `en` is 1 and its flag is 1. This is independent of `Result` and of FIFO state.
  - Each saturates at `16'hFFFF`.
- **Register map**
  - `Base`
    - Write: bit0 = `en` (stored), bit1 = clear (self-clearing pulse).
    - Read: {`en` in bit31, 20'b0, `Overflow` in bit10, full in bit9, empty in bit8, 3'b0, `count[4:0]`}.
  - `Base+1`, read: head `Result` word. No pop. Returns 0 when empty.
  - `Base+2`, read: {16'b0, head tag}. Returns 0 when empty.
    - Pops on the rising edge of `Read`, i.e. `Read`=1 in this cycle and 0 in the previous cycle with `Address == Base+2`.
    - Software reads `Base+1` first, then `Base+2`.
  - `Base+3`, read: {`pcnt`, `ecnt`}.
  - `Base+4`, read: {16'b0, `mcnt`}.
  - Writes to `Base+1` through `Base+4` are ignored.
- **DataOut**
  - Combinational from registered state.
  - Non-zero only while `Read`=1 and `Address` is within `Base` to `Base+4`.
- **Clear**
  - Flushes the FIFO (pointers and count to 0), clears `Overflow`, and clears all three counters.
  - `ts` and `en` are unaffected.
  - Clear has priority over a push and a pop in the same cycle.
- **Boundary conditions**
  - Full, push, no pop: the entry is dropped, `Overflow` is set, and `count` stays 16.
  - Full, push and pop in the same cycle: both are performed and `count` stays 16. `Overflow` is not set.
  - Empty, pop: ignored, and `count` stays 0.
  - Empty, push and pop in the same cycle: push only, so `count` becomes 1.
  - Pointers wrap modulo 2^DepthLog2.
  - `count` is 5 bits wide (0 to 16).

## Timing
- **Reset values**
  - `DataOut`=0, `NotEmpty`=0, `Overflow`=0.
  - FIFO empty, `count`=0, `ts`=0, all counters 0.
  - `en`=1, so capture runs without any configuration.
- **Capture latency**: inputs sampled at edge N become visible as head data, `count`, `NotEmpty` and counter values from edge N onward, i.e. readable in cycle N+1.
- **Pop latency**
  - The pop takes effect at the edge ending the first `Read` cycle.
  - The `Base+2` data returned in that first cycle is the pre-pop head.
  - Holding `Read` high for more cycles does not pop again.
- **Control write**: takes effect at the edge where `Write`=1. Clear completes in that single cycle.
- **Reset mid-operation**: `rst` overrides everything, including a concurrent push, pop or bus write.

## Test plan
- **Reset defaults**: assert `rst` for 2 cycles, then read `Base` -> `32'h80000100` (`en`=1, empty). Read `Base+1`, `Base+3` and `Base+4` -> 0.
- **Single hit**
  - Stimulus: `Result=32'h00000F00` with `Electron=1` for one cycle while `ts=5`.
  - Status read -> `count`=1.
  - Read `Base+1` -> `32'h00000F00`.
  - Read `Base+2` -> `32'h00002005`.
  - After that read, `count`=0 and `NotEmpty`=0.
  - Read `Base+3` -> `32'h00000001`.
- **Overflow**
  - Stimulus: 17 consecutive non-zero words `1` to `17`.
  - Required: `count`=16, `Overflow`=1.
  - 16 pops return `Result` 1 to 16 in order; word 17 is absent.
  - Then write `Base` = `32'h3` -> `Overflow`=0, counters 0, `en`=1.
- **Full with simultaneous pop**
  - Fill the FIFO to 16.
  - In the same cycle, drive a pop rising edge and push word `32'hA5`.
  - Required: `count`=16, `Overflow`=0, and `32'hA5` is the last entry.
- **Zero word and disable**
  - `Result=0` with `Muon=1`: no push, and `mcnt` increments.
  - Write `Base` = 0, then push a non-zero word with `Pion=1`: no push and no `pcnt` change.
- **Wrap and saturation**
  - Run 8192 cycles: the `ts` tag returns to its starting value.
  - Force 65540 `Electron` cycles: `ecnt` reads `16'hFFFF`.
